key_press_emulator: RTL and testbench
=====================================

# key_press_emulator

Synthesizes a pull-down button waveform from one-cycle short/long press requests, the inverse of the short/long key-press distinguisher. Lets IR-remote command decoding drive the fan's existing button-driven control paths (light colour/brightness, speed, timer) without a second decode path. Output `button` feeds the same input the physical button drives. The release gap is sized to clear the downstream edge detector/debouncer.

## Interface
- `SHORT_PRESS_CYCLES`, 10_000_000 — press length for a short request (100 ms @ 100 MHz); must be < the distinguisher's long threshold.
- `LONG_PRESS_CYCLES`, 150_000_000 — press length for a long request (1.5 s); must exceed the long threshold.
- `GAP_CYCLES`, 5_000_000 — forced release time after every press; must exceed downstream debounce.
- All parameters ≥ 1 and < 2^32.
- `clk` input 1 — system clock; one clock, everything on rising edge.
- `reset_p` input 1 — asynchronous, active-high reset.
- `req_short` input 1 — one-cycle request for a short press.
- `req_long` input 1 — one-cycle request for a long press.
- `abort` input 1 — terminate the current press immediately.
- `button` output 1 — emulated button level, 1 = pressed.
- `busy` output 1 — a press or gap is in progress.
- `done` output 1 — one-cycle pulse when a press+gap sequence completes or an aborted sequence finishes its gap.
- `dropped` output 1 — one-cycle pulse when a request is discarded.

## Operation
- FSM states: IDLE, PRESS, GAP. A 32-bit down-counter `cnt` times both timed states.
- IDLE → PRESS on a request: load `cnt` = P−1. P = LONG_PRESS_CYCLES if `req_long`, else SHORT_PRESS_CYCLES.
- `req_short` and `req_long` in the same cycle: long wins. No `dropped` pulse.
- PRESS: `button`=1. At `cnt`==0 → GAP, load `cnt` = GAP_CYCLES−1.
- GAP: `button`=0. At `cnt`==0 → IDLE with `done`=1, or directly to PRESS if a queued request exists (see Configuration).
- Otherwise `cnt` decrements by 1 each cycle in PRESS and GAP. Arithmetic never wraps: `cnt` is only decremented when nonzero.
- `abort` in PRESS: → GAP next edge with full gap reload; `button` falls next edge; pending request cleared.
- `abort` in GAP: pending request cleared; gap continues unchanged.
- `abort` in IDLE: no effect.
- `abort` has priority over a simultaneous request. That request is dropped with a `dropped` pulse.
- Requests arriving in PRESS or GAP are handled per Configuration.
- `busy` = (state ≠ IDLE). `button`, `busy`, `done`, `dropped` are all registered outputs.
- Reset mid-operation: state IDLE, `cnt`=0, pending cleared, all outputs 0 on the reset edge. The press is truncated with no `done`.

## Timing
- Reset values: `button`=0, `busy`=0, `done`=0, `dropped`=0.
- Request sampled at edge E0 in IDLE:
  - `button`=1 and `busy`=1 after E0, for exactly P cycles.
  - `button`=0 after E_P, for G cycles.
  - After E_(P+G): `busy`=0 and `done`=1 for one cycle.
- Idle-to-idle sequence occupies P+G cycles. The next request is accepted at the edge following `done`.
- `abort` sampled at edge Ea in PRESS: `button`=0 after Ea; `done` after Ea+G.
- `dropped` is asserted the cycle after the discarded request's edge.

## Configuration
- Macro `KEY_PRESS_EMU_QUEUE_EN`.
- Defined: one-entry pending register, storing type only.
  - A request in PRESS/GAP with pending empty is stored.
  - If pending is full, or two requests arrive while pending is full, the new one is dropped (`dropped`=1). A simultaneous long+short into empty pending stores long.
  - At GAP end with pending valid: `done`=1, `busy` stays 1, state → PRESS with the pending duration; pending clears the same edge.
- Not defined: no pending register. Every request in PRESS/GAP is dropped with a `dropped` pulse. GAP always returns to IDLE.

## Test plan
Params SHORT=4, LONG=10, GAP=3.
- Reset, then `req_short` pulse at E0 → `button` high 4 cycles, low 3, `done` 1 cycle at E7, `busy` high E0–E6.
- `req_short`+`req_long` same cycle → `button` high 10 cycles, `dropped` stays 0.
- `abort` 2 cycles into long press → `button` falls next edge, `done` 3 cycles later, no further press.
- Queue on: `req_long` then `req_short` during press → 10-high/3-low, `done` with `busy` held, then 4-high/3-low, `done`, `busy`=0. A third request during press → `dropped` pulse. Queue off: second request → `dropped`, single press only.
- `reset_p` asserted mid-PRESS → `button`/`busy` 0 immediately, no `done`; after release a new `req_short` yields a normal 4-cycle press.

Source files
------------

// File: rtl/key_press_emulator_if.sv
// key_press_emulator_if: request/abort inputs and button/status outputs of the key-press emulator.
// Signals:
//   req_short, req_long, abort : one-cycle commands into the emulator
//   button, busy, done, dropped : emulated button level and registered status
// Modports: master drives commands and observes status, slave is the emulator side.
interface key_press_emulator_if;
    logic req_short;
    logic req_long;
    logic abort;
    logic button;
    logic busy;
    logic done;
    logic dropped;
    modport master (output req_short, req_long, abort, input button, busy, done, dropped);
    modport slave (input req_short, req_long, abort, output button, busy, done, dropped);
endinterface

// File: rtl/key_press_emulator.sv
// key_press_emulator: turns one-cycle short/long press requests into a timed button press followed by a release gap.
// Ports:
//   clk     : system clock, rising edge
//   reset_p : asynchronous active-high reset
//   bus     : key_press_emulator_if.slave (req_short, req_long, abort in; button, busy, done, dropped out)
// Parameters: SHORT_PRESS_CYCLES, LONG_PRESS_CYCLES, GAP_CYCLES (all >= 1).
// Define KEY_PRESS_EMU_QUEUE_EN to hold one request that arrives during a press or gap;
// without it every such request is dropped.
module key_press_emulator #(
    parameter int unsigned SHORT_PRESS_CYCLES = 10_000_000,
    parameter int unsigned LONG_PRESS_CYCLES  = 150_000_000,
    parameter int unsigned GAP_CYCLES         = 5_000_000
) (
    input logic clk,
    input logic reset_p,
    key_press_emulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
    localparam logic [31:0] S1 = 32'(SHORT_PRESS_CYCLES - 1);
    localparam logic [31:0] L1 = 32'(LONG_PRESS_CYCLES - 1);
    localparam logic [31:0] G1 = 32'(GAP_CYCLES - 1);
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        done_n, drop_n;
    logic        req_any;
    logic [31:0] req_len;
    assign req_any = bus.req_short | bus.req_long;
    assign req_len = bus.req_long ? L1 : S1;
`ifdef KEY_PRESS_EMU_QUEUE_EN
    logic pend_v, pend_v_n, pend_long, pend_long_n;
`endif
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.button  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.dropped <= 1'b0;
`ifdef KEY_PRESS_EMU_QUEUE_EN
            pend_v      <= 1'b0;
            pend_long   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bus.button  <= state_n == PRESS;
            bus.busy    <= state_n != IDLE;
            bus.done    <= done_n;
            bus.dropped <= drop_n;
`ifdef KEY_PRESS_EMU_QUEUE_EN
            pend_v      <= pend_v_n;
            pend_long   <= pend_long_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        drop_n  = 1'b0;
`ifdef KEY_PRESS_EMU_QUEUE_EN
        pend_v_n    = pend_v;
        pend_long_n = pend_long;
`endif
        case (state)
            IDLE: begin
                // abort outranks a simultaneous request, which is then discarded
                if (req_any && bus.abort) begin
                    drop_n = 1'b1;
                end else if (req_any) begin
                    state_n = PRESS;
                    cnt_n   = req_len;
                end
            end
            PRESS: begin
                if (bus.abort) begin
                    state_n = GAP;
                    cnt_n   = G1;
                    drop_n  = req_any;
`ifdef KEY_PRESS_EMU_QUEUE_EN
                    pend_v_n = 1'b0;
`endif
                end else begin
                    state_n = cnt == '0 ? GAP : PRESS;
                    cnt_n   = cnt == '0 ? G1 : cnt - 1'b1;
`ifdef KEY_PRESS_EMU_QUEUE_EN
                    if (req_any && pend_v) begin
                        drop_n = 1'b1;
                    end else if (req_any) begin
                        pend_v_n    = 1'b1;
                        pend_long_n = bus.req_long;
                    end
`else
                    drop_n = req_any;
`endif
                end
            end
            GAP: begin
                if (bus.abort) begin
                    // gap keeps running untouched; only the queued request goes away
                    drop_n  = req_any;
                    state_n = cnt == '0 ? IDLE : GAP;
                    done_n  = cnt == '0;
                    cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
`ifdef KEY_PRESS_EMU_QUEUE_EN
                    pend_v_n = 1'b0;
`endif
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
`ifdef KEY_PRESS_EMU_QUEUE_EN
                    if (req_any && pend_v) begin
                        drop_n = 1'b1;
                    end else if (req_any) begin
                        pend_v_n    = 1'b1;
                        pend_long_n = bus.req_long;
                    end
`else
                    drop_n = req_any;
`endif
                end else begin
                    done_n = 1'b1;
`ifdef KEY_PRESS_EMU_QUEUE_EN
                    // a request landing on the final gap cycle is launched directly so it cannot be stranded in IDLE
                    if (pend_v) begin
                        state_n  = PRESS;
                        cnt_n    = pend_long ? L1 : S1;
                        pend_v_n = 1'b0;
                        drop_n   = req_any;
                    end else if (req_any) begin
                        state_n = PRESS;
                        cnt_n   = req_len;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
                    drop_n  = req_any;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_key_press_emulator.sv
// tb_key_press_emulator: directed checks of press/gap timing, long-wins, abort, queueing/dropping and mid-press reset.
// Ports: none (top-level bench); drives key_press_emulator_if as master.
// Honors KEY_PRESS_EMU_QUEUE_EN to pick the queue-on or queue-off expectations.
module tb_key_press_emulator;
    logic clk = 1'b0;
    logic reset_p = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    key_press_emulator_if bus_if ();
    key_press_emulator #(
        .SHORT_PRESS_CYCLES(4),
        .LONG_PRESS_CYCLES (10),
        .GAP_CYCLES        (3)
    ) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .bus    (bus_if.slave)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask
    // Called just after the edge at index start of a press of p cycles and a gap of g cycles;
    // returns just after the closing edge having checked done and the busy level there.
    task automatic expect_seq(input string tag, input int p, input int g, input logic busy_after, input int start);
        for (int i = start; i < p + g; i++) begin
            chk({tag, ".button"}, bus_if.button, i < p);
            chk({tag, ".busy"}, bus_if.busy, 1'b1);
            chk({tag, ".done"}, bus_if.done, 1'b0);
            chk({tag, ".dropped"}, bus_if.dropped, 1'b0);
            tick();
        end
        chk({tag, ".end_done"}, bus_if.done, 1'b1);
        chk({tag, ".end_busy"}, bus_if.busy, busy_after);
    endtask
    initial begin
        bus_if.req_short = 1'b0;
        bus_if.req_long  = 1'b0;
        bus_if.abort     = 1'b0;
        tick();
        tick();
        chk("rst.button", bus_if.button, 1'b0);
        chk("rst.busy", bus_if.busy, 1'b0);
        chk("rst.done", bus_if.done, 1'b0);
        chk("rst.dropped", bus_if.dropped, 1'b0);
        reset_p = 1'b0;
        tick();
        // short press: 4 high, 3 low, done after E7
        bus_if.req_short = 1'b1;
        tick();
        bus_if.req_short = 1'b0;
        expect_seq("short", 4, 3, 1'b0, 0);
        chk("short.end_button", bus_if.button, 1'b0);
        tick();
        chk("short.done_clear", bus_if.done, 1'b0);
        // short+long together: long wins, nothing dropped
        bus_if.req_short = 1'b1;
        bus_if.req_long  = 1'b1;
        tick();
        bus_if.req_short = 1'b0;
        bus_if.req_long  = 1'b0;
        expect_seq("both", 10, 3, 1'b0, 0);
        tick();
        chk("both.done_clear", bus_if.done, 1'b0);
        chk("both.dropped", bus_if.dropped, 1'b0);
        // abort two cycles into a long press
        bus_if.req_long = 1'b1;
        tick();
        bus_if.req_long = 1'b0;
        chk("abort.pre_button", bus_if.button, 1'b1);
        tick();
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        expect_seq("abort", 0, 3, 1'b0, 0);
        tick();
        chk("abort.idle_button", bus_if.button, 1'b0);
        chk("abort.idle_busy", bus_if.busy, 1'b0);
        tick();
        chk("abort.no_press", bus_if.button, 1'b0);
`ifdef KEY_PRESS_EMU_QUEUE_EN
        // long, queued short, third request dropped
        bus_if.req_long = 1'b1;
        tick();
        bus_if.req_long  = 1'b0;
        bus_if.req_short = 1'b1;
        tick();
        chk("queue.stored_no_drop", bus_if.dropped, 1'b0);
        tick();
        bus_if.req_short = 1'b0;
        chk("queue.third_dropped", bus_if.dropped, 1'b1);
        tick();
        expect_seq("queue.first", 10, 3, 1'b1, 3);
        expect_seq("queue.second", 4, 3, 1'b0, 0);
        tick();
        chk("queue.idle_busy", bus_if.busy, 1'b0);
        chk("queue.idle_button", bus_if.button, 1'b0);
`else
        // second request during a press is dropped; single press only
        bus_if.req_long = 1'b1;
        tick();
        bus_if.req_long  = 1'b0;
        bus_if.req_short = 1'b1;
        tick();
        bus_if.req_short = 1'b0;
        chk("noqueue.dropped", bus_if.dropped, 1'b1);
        tick();
        expect_seq("noqueue", 10, 3, 1'b0, 2);
        chk("noqueue.end_button", bus_if.button, 1'b0);
        tick();
        chk("noqueue.idle_busy", bus_if.busy, 1'b0);
        chk("noqueue.idle_button", bus_if.button, 1'b0);
`endif
        // reset in the middle of a press
        bus_if.req_short = 1'b1;
        tick();
        bus_if.req_short = 1'b0;
        tick();
        chk("mid.button", bus_if.button, 1'b1);
        reset_p = 1'b1;
        #1;
        chk("mid.rst_button", bus_if.button, 1'b0);
        chk("mid.rst_busy", bus_if.busy, 1'b0);
        tick();
        chk("mid.rst_done", bus_if.done, 1'b0);
        reset_p = 1'b0;
        tick();
        chk("mid.post_done", bus_if.done, 1'b0);
        chk("mid.post_busy", bus_if.busy, 1'b0);
        bus_if.req_short = 1'b1;
        tick();
        bus_if.req_short = 1'b0;
        expect_seq("after_rst", 4, 3, 1'b0, 0);
        tick();
        chk("after_rst.done_clear", bus_if.done, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
